// File: rtl/matrix_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : matrix_add_seq
// Purpose  : Sequential element-wise adder/subtractor for flattened N x N
//            matrices of W-bit elements. It processes LANES elements per
//            cycle and holds the result with a sticky overflow flag until
//            the consumer accepts it.
// Options  : SATURATE_EN - when defined, results clamp on overflow instead
//            of wrapping. Add clamps to 2^W-1; sub clamps to 0.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_add_seq #(
  parameter int N     = 3,
  parameter int W     = 3,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*N*W-1:0] in_a,
  input  logic [N*N*W-1:0] in_b,
  input  logic             in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*N*W-1:0] out_result,
  output logic             out_ovf
);

  localparam int NE = N * N;
  localparam int IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - LANES);
  localparam logic [IW-1:0] STEP     = IW'(LANES);

  // A lane count that does not tile the matrix would leave elements unwritten.
  generate
    if ((N < 1) || (LANES < 1) || ((NE % LANES) != 0)) begin : g_param_check
      $error("matrix_add_seq: LANES must divide N*N and N must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NE*W-1:0]  a_q, a_d;
  logic [NE*W-1:0]  b_q, b_d;
  logic             op_q, op_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [NE*W-1:0]  res_q, res_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0]     lane_val_w [LANES];
  logic [LANES-1:0] lane_ovf_w;

  // One arithmetic slice per lane, working on element idx_q + lane.
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [W-1:0] opa_w, opb_w, raw_w;
      logic [W:0]   sum_w, diff_w;

      assign opa_w  = a_q[(int'(idx_q) + g) * W +: W];
      assign opb_w  = b_q[(int'(idx_q) + g) * W +: W];
      assign sum_w  = {1'b0, opa_w} + {1'b0, opb_w};
      // The extra top bit of the difference is the borrow (A < B).
      assign diff_w = {1'b0, opa_w} - {1'b0, opb_w};
      assign raw_w  = op_q ? diff_w[W-1:0] : sum_w[W-1:0];
      assign lane_ovf_w[g] = op_q ? diff_w[W] : sum_w[W];
`ifdef SATURATE_EN
      assign lane_val_w[g] = lane_ovf_w[g] ? (op_q ? {W{1'b0}} : {W{1'b1}}) : raw_w;
`else
      assign lane_val_w[g] = raw_w;
`endif
    end
  endgenerate

  // Next-state logic: capture in IDLE, write LANES elements per RUN beat, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    idx_d   = idx_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          op_d    = in_op;
          idx_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int l = 0; l < LANES; l++) begin
          res_d[(int'(idx_q) + l) * W +: W] = lane_val_w[l];
        end
        ovf_d = ovf_q | (|lane_ovf_w);
        idx_d = idx_q + STEP;
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Returning to IDLE first keeps the result handshake and the next accept in separate cycles.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_result = res_q;
  assign out_ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_add_seq
// Purpose  : Directed self-checking bench for matrix_add_seq (N=3, W=3).
//            A LANES=1 instance and a LANES=3 instance share the stimulus.
//            Expected values follow SATURATE_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_add_seq;

  localparam int N  = 3;
  localparam int W  = 3;
  localparam int MW = N * N * W;
`ifdef SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [MW-1:0] in_a, in_b;
  logic          in_op;
  logic          out_ready;
  logic          in_ready,  out_valid,  out_ovf;
  logic [MW-1:0] out_result;
  logic          in_ready3, out_valid3, out_ovf3;
  logic [MW-1:0] out_result3;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matrix_add_seq #(.N(N), .W(W), .LANES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_ovf(out_ovf)
  );

  matrix_add_seq #(.N(N), .W(W), .LANES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid3),
    .out_ready(out_ready), .out_result(out_result3), .out_ovf(out_ovf3)
  );

  // Same value in all nine elements.
  function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < N * N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  // Present one job, then count edges after the accepting edge until out_valid.
  task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic op,
                         output int lat1, output int lat3);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready: in_ready=%b want 1", in_ready);
    end
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat1 = -1; lat3 = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (lat3 < 0 && out_valid3 === 1'b1) lat3 = c;
      if (out_valid === 1'b1) begin
        lat1 = c;
        break;
      end
    end
  endtask

  // Accept the result and check the return to IDLE.
  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL cold_reset: rdy=%b vld=%b res=%h ovf=%b want 1/0/0/0",
                         in_ready, out_valid, out_result, out_ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int l1, l3;
    run_job(fill(3'd3), fill(3'd2), 1'b0, l1, l3);
    n_vec++;
    if (l1 !== 9) begin n_fail++; $display("FAIL basic_lat1: got %0d want 9", l1); end
    n_vec++;
    if (l3 !== 3) begin n_fail++; $display("FAIL basic_lat3: got %0d want 3", l3); end
    n_vec++;
    if (out_result !== fill(3'd5) || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic_res1: got %h/%b want %h/0", out_result, out_ovf, fill(3'd5));
    end
    n_vec++;
    if (out_result3 !== fill(3'd5) || out_ovf3 !== 1'b0) begin
      n_fail++; $display("FAIL basic_res3: got %h/%b want %h/0", out_result3, out_ovf3, fill(3'd5));
    end
  endtask

  // Both instances sit in DONE with a nonzero result; reset must clear them between edges.
  task automatic test_reset_async();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: rdy=%b vld=%b res=%h ovf=%b want 1/0/0/0",
                         in_ready, out_valid, out_result, out_ovf);
    end
    n_vec++;
    if (in_ready3 !== 1'b1 || out_valid3 !== 1'b0 || out_result3 !== '0) begin
      n_fail++; $display("FAIL async_reset3: rdy=%b vld=%b res=%h want 1/0/0",
                         in_ready3, out_valid3, out_result3);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    int l1, l3;
    logic [MW-1:0] exp_r;
    run_job(27'd7, 27'd1, 1'b0, l1, l3);
    exp_r = SAT ? 27'd7 : 27'd0;
    n_vec++;
    if (out_result !== exp_r || out_ovf !== 1'b1) begin
      n_fail++; $display("FAIL add_ovf: got %h/%b want %h/1", out_result, out_ovf, exp_r);
    end
    drain();
    // Distinct element values expose element ordering; element 7 overflows.
    run_job({3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, fill(3'd1), 1'b0, l1, l3);
    exp_r = SAT ? {3'd1, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}
                : {3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    n_vec++;
    if (out_result !== exp_r || out_ovf !== 1'b1) begin
      n_fail++; $display("FAIL add_mixed1: got %h/%b want %h/1", out_result, out_ovf, exp_r);
    end
    n_vec++;
    if (out_result3 !== exp_r || out_ovf3 !== 1'b1) begin
      n_fail++; $display("FAIL add_mixed3: got %h/%b want %h/1", out_result3, out_ovf3, exp_r);
    end
    drain();
  endtask

  task automatic test_sub();
    int l1, l3;
    logic [MW-1:0] exp_r;
    run_job(fill(3'd2), fill(3'd5), 1'b1, l1, l3);
    exp_r = SAT ? fill(3'd0) : fill(3'd5);
    n_vec++;
    if (out_result !== exp_r || out_ovf !== 1'b1) begin
      n_fail++; $display("FAIL sub_borrow: got %h/%b want %h/1", out_result, out_ovf, exp_r);
    end
    drain();
    run_job(fill(3'd6), fill(3'd1), 1'b1, l1, l3);
    n_vec++;
    if (out_result !== fill(3'd5) || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL sub_plain: got %h/%b want %h/0", out_result, out_ovf, fill(3'd5));
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int l1, l3;
    run_job(fill(3'd3), fill(3'd4), 1'b0, l1, l3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0];
      in_a = fill(3'(k));
      in_b = fill(3'd1);
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== fill(3'd7) || out_ovf !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d: vld=%b rdy=%b res=%h ovf=%b want 1/0/%h/0",
                           k, out_valid, in_ready, out_result, out_ovf, fill(3'd7));
      end
    end
    // in_valid is high across the result handshake; it must not be accepted then.
    @(negedge clk);
    in_valid = 1'b1; in_a = fill(3'd1); in_b = fill(3'd1); in_op = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL release: vld=%b rdy=%b want 0/1", out_valid, in_ready);
    end
    run_job(fill(3'd5), fill(3'd1), 1'b1, l1, l3);
    n_vec++;
    if (l1 !== 9 || out_result !== fill(3'd4) || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL next_job: lat=%0d res=%h ovf=%b want 9/%h/0", l1, out_result, out_ovf, fill(3'd4));
    end
    drain();
  endtask

  task automatic test_reset_midrun();
    int l1, l3;
    @(negedge clk);
    in_a = fill(3'd7); in_b = fill(3'd7); in_op = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: rdy=%b vld=%b res=%h ovf=%b want 1/0/0/0",
                         in_ready, out_valid, out_result, out_ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_job(fill(3'd1), fill(3'd2), 1'b0, l1, l3);
    n_vec++;
    if (l1 !== 9 || l3 !== 3) begin
      n_fail++; $display("FAIL post_reset_lat: got %0d/%0d want 9/3", l1, l3);
    end
    n_vec++;
    if (out_result !== fill(3'd3) || out_ovf !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_res: got %h/%b want %h/0", out_result, out_ovf, fill(3'd3));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_async();
    test_add_overflow();
    test_sub();
    test_back_to_back();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
